spi_peripheral: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0), MSB-first peripheral (responder).
- Sits at the far end of the link driven by the team's SPI controller and clock divider.
- Oversamples the external SCLK, CS_n and MOSI in the i_clk domain, shifts in 8-bit receive bytes and shifts out 8-bit transmit bytes.
- Supports multi-byte frames while CS_n stays low; the host side uses a one-byte transmit holding register with a valid/ready handshake.

---
 rtl/spi_peripheral.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 MSB-first peripheral; oversamples SCLK/CS_n/MOSI in the i_clk domain.
// Latency: o_rx_data/o_rx_valid one cycle after the synchronized 8th SCLK rise; MISO one cycle after TX register update.
// Backpressure: none on RX (unread bytes are overwritten); TX holding register accepts on i_tx_valid & o_tx_ready.
//
// Ports:
//   i_clk, i_rst            system clock, asynchronous active-high reset
//   i_sclk, i_cs_n, i_mosi  SPI inputs, asynchronous to i_clk
//   o_miso, o_miso_oe       SPI data out and its output enable
//   i_tx_data/i_tx_valid/o_tx_ready  one-byte transmit holding register handshake
//   o_tx_underrun           pulse: byte slot started with holding register empty (0x00 sent)
//   o_rx_data/o_rx_valid    last complete received byte and its update pulse
//   o_rx_abort              pulse: CS_n rose with a partial byte received
//   o_busy                  high while a frame is active
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_abort,
  output logic       o_busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers plus one extra registered copy for edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // ---------------------------------------------------------------------------
  // Frame FSM: state register / next state / control strobes
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] bit_cnt;
  // Set once an SCLK rise has been seen since the last TX load, so a falling
  // edge at count 0 right after the CS_n-fall load is not treated as a byte
  // boundary.
  logic       armed;

  logic load_tx;
  logic shift_tx;
  logic rx_shift;
  logic frame_end;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CS_n edges take priority over any SCLK edge seen in the same cycle.
  always_comb begin
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    rx_shift  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) load_tx = 1'b1;
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_end = 1'b1;
        end else if (sclk_rise) begin
          rx_shift = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt != 3'd0) shift_tx = 1'b1;
          else if (armed)      load_tx  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit holding register
  // ---------------------------------------------------------------------------
  logic       hold_full;
  logic [7:0] hold_q;
  logic       tx_wr;

  assign tx_wr      = i_tx_valid & ~hold_full;
  assign o_tx_ready = ~hold_full;

  // A load in the same cycle as a write into an empty register sees it empty;
  // the written byte waits for the following slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_full <= 1'b0;
      hold_q    <= 8'h00;
    end else if (load_tx && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_wr) begin
      hold_full <= 1'b1;
      hold_q    <= i_tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift registers, bit counter and status pulses
  // ---------------------------------------------------------------------------
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_sr         <= 8'h00;
      rx_sr         <= 8'h00;
      bit_cnt       <= 3'd0;
      armed         <= 1'b0;
      o_rx_data     <= 8'h00;
      o_rx_valid    <= 1'b0;
      o_rx_abort    <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_rx_abort    <= 1'b0;
      o_tx_underrun <= 1'b0;
      if (frame_end) begin
        // Partial RX data and any unsent TX byte are dropped.
        o_rx_abort <= (bit_cnt != 3'd0);
        bit_cnt    <= 3'd0;
        rx_sr      <= 8'h00;
        tx_sr      <= 8'h00;
        armed      <= 1'b0;
      end else if (rx_shift) begin
        rx_sr   <= {rx_sr[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        armed   <= 1'b1;
        if (bit_cnt == 3'd7) begin
          o_rx_data  <= {rx_sr[6:0], mosi_s};
          o_rx_valid <= 1'b1;
        end
      end else if (shift_tx) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end else if (load_tx) begin
        tx_sr         <= hold_full ? hold_q : 8'h00;
        o_tx_underrun <= ~hold_full;
        armed         <= 1'b0;
        if (state_q == IDLE) begin
          bit_cnt <= 3'd0;
          rx_sr   <= 8'h00;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered SPI outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_miso    <= 1'b0;
      o_miso_oe <= 1'b0;
    end else begin
      o_miso_oe <= ~cs_s;
      if (state_q == ACTIVE && !frame_end) o_miso <= tx_sr[7];
      else                                 o_miso <= 1'b0;
    end
  end

  assign o_busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral acting as an SPI mode-0 controller (divisor 8).
// Every drive happens 1 ns after a rising i_clk edge; outputs are sampled there or on negedge.
// The final SCLK fall of each frame coincides with the CS_n rise, so no trailing slot is loaded.
module tb_spi_peripheral;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_miso_oe;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_tx_underrun;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_abort;
  logic       o_busy;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sclk       (i_sclk),
    .i_cs_n       (i_cs_n),
    .i_mosi       (i_mosi),
    .o_miso       (o_miso),
    .o_miso_oe    (o_miso_oe),
    .i_tx_data    (i_tx_data),
    .i_tx_valid   (i_tx_valid),
    .o_tx_ready   (o_tx_ready),
    .o_tx_underrun(o_tx_underrun),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_rx_abort   (o_rx_abort),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rxv    = 0;
  int         n_und    = 0;
  int         n_abt    = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mi;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_rx_valid) begin
      n_rxv++;
      rx_q.push_back(o_rx_data);
    end
    if (o_tx_underrun) n_und++;
    if (o_rx_abort)    n_abt++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_counts();
    n_rxv = 0;
    n_und = 0;
    n_abt = 0;
    rx_q.delete();
  endtask

  task automatic tx_write(input logic [7:0] d);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    wait_cyc(1);
    i_tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    i_cs_n = 1'b0;
    wait_cyc(6);
  endtask

  task automatic cs_high();
    i_cs_n = 1'b1;
    i_sclk = 1'b0;
    wait_cyc(6);
  endtask

  // Clock nbits of a byte MSB first; SCLK is left high after the last rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi_o);
    mi_o = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      i_sclk = 1'b0;
      i_mosi = mo[7-i];
      wait_cyc(4);
      mi_o   = {mi_o[6:0], o_miso};
      i_sclk = 1'b1;
      wait_cyc(4);
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_sclk     = 1'b0;
    i_cs_n     = 1'b1;
    i_mosi     = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
    wait_cyc(3);

    // Reset values
    check("rst_miso",     o_miso,        1'b0);
    check("rst_miso_oe",  o_miso_oe,     1'b0);
    check("rst_tx_ready", o_tx_ready,    1'b1);
    check("rst_rx_data",  o_rx_data,     8'h00);
    check("rst_rx_valid", o_rx_valid,    1'b0);
    check("rst_underrun", o_tx_underrun, 1'b0);
    check("rst_abort",    o_rx_abort,    1'b0);
    check("rst_busy",     o_busy,        1'b0);
    i_rst = 1'b0;
    wait_cyc(3);

    // Reset asserted after 4 SCLK rises
    clear_counts();
    tx_write(8'hE7);
    cs_low();
    spi_bits(8'hB4, 4, mi);
    check("t1_miso_nibble", {28'h0, mi[3:0]}, 32'hE);
    check("t1_busy_before", o_busy, 1'b1);
    i_rst = 1'b1;
    #1;
    check("t1_miso",     o_miso,     1'b0);
    check("t1_miso_oe",  o_miso_oe,  1'b0);
    check("t1_tx_ready", o_tx_ready, 1'b1);
    check("t1_busy",     o_busy,     1'b0);
    check("t1_rx_data",  o_rx_data,  8'h00);
    i_cs_n = 1'b1;
    i_sclk = 1'b0;
    wait_cyc(3);
    i_rst = 1'b0;
    wait_cyc(6);
    check("t1_no_rxv",   n_rxv, 0);
    check("t1_no_abort", n_abt, 0);
    check("t1_idle",     o_busy, 1'b0);

    // Single byte: TX 0xA5, RX 0x3C
    clear_counts();
    tx_write(8'hA5);
    check("t2_ready_low", o_tx_ready, 1'b0);
    cs_low();
    check("t2_busy",    o_busy,    1'b1);
    check("t2_oe",      o_miso_oe, 1'b1);
    spi_bits(8'h3C, 8, mi);
    check("t2_miso", mi, 8'hA5);
    cs_high();
    check("t2_rx_data",  o_rx_data,  8'h3C);
    check("t2_rxv_cnt",  n_rxv,      1);
    check("t2_tx_ready", o_tx_ready, 1'b1);
    check("t2_und_cnt",  n_und,      0);
    check("t2_abt_cnt",  n_abt,      0);

    // Underrun: nothing written, RX 0xFF
    clear_counts();
    cs_low();
    check("t3_und_at_load", n_und, 1);
    spi_bits(8'hFF, 8, mi);
    check("t3_miso", mi, 8'h00);
    cs_high();
    check("t3_rx_data", o_rx_data, 8'hFF);
    check("t3_rxv_cnt", n_rxv,     1);
    check("t3_und_cnt", n_und,     1);

    // Two bytes under one CS_n
    clear_counts();
    tx_write(8'h11);
    cs_low();
    begin
      int k = 0;
      while (!o_tx_ready && k < 50) begin
        wait_cyc(1);
        k++;
      end
    end
    check("t4_ready_wait", o_tx_ready, 1'b1);
    tx_write(8'h22);
    spi_bits(8'h81, 8, mi);
    check("t4_miso0", mi, 8'h11);
    spi_bits(8'h7E, 8, mi);
    check("t4_miso1", mi, 8'h22);
    cs_high();
    check("t4_rxv_cnt",  n_rxv,      2);
    check("t4_rx0",      rx_q[0],    8'h81);
    check("t4_rx1",      rx_q[1],    8'h7E);
    check("t4_und_cnt",  n_und,      0);
    check("t4_tx_ready", o_tx_ready, 1'b1);

    // Abort after 3 rises
    clear_counts();
    cs_low();
    spi_bits(8'hA0, 3, mi);
    i_cs_n = 1'b1;
    i_sclk = 1'b0;
    wait_cyc(4);
    check("t5_oe_off", o_miso_oe, 1'b0);
    wait_cyc(4);
    check("t5_abt_cnt", n_abt,     1);
    check("t5_rxv_cnt", n_rxv,     0);
    check("t5_rx_data", o_rx_data, 8'h7E);
    check("t5_busy",    o_busy,    1'b0);
    check("t5_miso",    o_miso,    1'b0);

    // SCLK toggling while deselected
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      i_mosi = 1'b1;
      i_sclk = 1'b1;
      wait_cyc(4);
      i_sclk = 1'b0;
      wait_cyc(4);
    end
    check("t6_idle_rxv",  n_rxv,     0);
    check("t6_idle_abt",  n_abt,     0);
    check("t6_idle_busy", o_busy,    1'b0);
    check("t6_idle_data", o_rx_data, 8'h7E);

    // Write in the CS_n-fall load cycle with an empty register
    i_cs_n = 1'b0;
    wait_cyc(2);
    i_tx_data  = 8'h5A;
    i_tx_valid = 1'b1;
    wait_cyc(1);
    i_tx_valid = 1'b0;
    check("t6_und_pulse", o_tx_underrun, 1'b1);
    check("t6_held",      o_tx_ready,    1'b0);
    wait_cyc(4);
    spi_bits(8'hC3, 8, mi);
    check("t6_miso0", mi, 8'h00);
    spi_bits(8'h96, 8, mi);
    check("t6_miso1", mi, 8'h5A);
    cs_high();
    check("t6_und_cnt",  n_und,      1);
    check("t6_rxv_cnt",  n_rxv,      2);
    check("t6_rx0",      rx_q[0],    8'hC3);
    check("t6_rx1",      rx_q[1],    8'h96);
    check("t6_tx_ready", o_tx_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
